// File: rtl/ftdi_pkg.sv
// Shared types and constants for the FT245-style FIFO bridge.
package ftdi_pkg;

    localparam int FTDI_DW = 8;

    typedef enum logic [2:0] {
        IDLE,
        RD_STROBE,
        WR_SETUP,
        WR_STROBE,
        WR_HOLD,
        RECOVER
    } state_e;

    typedef enum logic {
        READ,
        WRITE
    } op_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy output.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign level_o = count_q;

    // Push+pop on empty passes the incoming word straight through; on full the
    // popped slot is the one being rewritten, so both cases keep the level.
    assign do_pop  = pop_i  & (~empty_o | push_i);
    assign do_push = push_i & (~full_o  | pop_i);
    assign rdata_o = empty_o ? wdata_i : mem_q[rd_ptr_q];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (do_push && !do_pop)      count_q <= count_q + 1'b1;
            else if (do_pop && !do_push) count_q <= count_q - 1'b1;
        end
    end

    // NOTE: storage has no reset; pointers and count alone define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/ftdi_fifo_bridge.sv
// FT245-style async USB FIFO controller: arbitrates reads/writes, times the strobes, buffers both directions.
module ftdi_fifo_bridge
    import ftdi_pkg::*;
#(
    parameter int RX_DEPTH = 16,
    parameter int TX_DEPTH = 16,
    parameter int RD_PULSE = 2,
    parameter int WR_PULSE = 2,
    parameter int RECOV    = 3
) (
    input  logic                        clk,
    input  logic                        n_rst,
    input  logic                        rxf_n,
    input  logic                        txe_n,
    output logic                        rd_n,
    output logic                        wr_n,
    inout  wire  [FTDI_DW-1:0]          dq,
    output logic [FTDI_DW-1:0]          rx_data,
    output logic                        rx_valid,
    input  logic                        rx_ready,
    input  logic [FTDI_DW-1:0]          tx_data,
    input  logic                        tx_valid,
    output logic                        tx_ready,
    output logic [$clog2(RX_DEPTH):0]   rx_level,
    output logic [$clog2(TX_DEPTH):0]   tx_level
);
    localparam int CNT_MAX = max3(RD_PULSE, WR_PULSE + 1, RECOV);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    state_e             state_q, state_d;
    op_e                last_op_q, last_op_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         rxf_sync_q, txe_sync_q;
    logic               rd_n_q, wr_n_q, dq_oe_q, rd_push_q;
    logic [FTDI_DW-1:0] rd_data_q, wr_data_q, tx_head;
    logic               rxf_s, txe_s, can_rd, can_wr;
    logic               rx_full, rx_empty, tx_full, tx_empty;
    logic               rd_capture, wr_load, tx_pop;

    assign rxf_s  = rxf_sync_q[1];
    assign txe_s  = txe_sync_q[1];
    assign can_rd = ~rxf_s & ~rx_full;
    assign can_wr = ~txe_s & ~tx_empty;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        last_op_d  = last_op_q;
        rd_capture = 1'b0;
        wr_load    = 1'b0;
        tx_pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (can_rd && (!can_wr || last_op_q == WRITE)) begin
                    state_d   = RD_STROBE;
                    cnt_d     = CNT_W'(RD_PULSE - 1);
                    last_op_d = READ;
                end else if (can_wr) begin
                    state_d   = WR_SETUP;
                    last_op_d = WRITE;
                    wr_load   = 1'b1;
                end
            end
            RD_STROBE: begin
                if (cnt_q == '0) begin
                    rd_capture = 1'b1;
                    state_d    = RECOVER;
                    cnt_d      = CNT_W'(RECOV - 1);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            WR_SETUP: begin
                state_d = WR_STROBE;
                cnt_d   = CNT_W'(WR_PULSE - 1);
            end
            WR_STROBE: begin
                if (cnt_q == '0) begin
                    tx_pop  = 1'b1;
                    state_d = WR_HOLD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            WR_HOLD: begin
                state_d = RECOVER;
                cnt_d   = CNT_W'(RECOV - 1);
            end
            RECOVER: begin
                if (cnt_q == '0) state_d = IDLE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // Pin-facing strobes and bus enable are registered from the next state: glitch-free, no added latency.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= IDLE;
            last_op_q  <= WRITE;
            cnt_q      <= '0;
            rxf_sync_q <= 2'b11;
            txe_sync_q <= 2'b11;
            rd_n_q     <= 1'b1;
            wr_n_q     <= 1'b1;
            dq_oe_q    <= 1'b0;
            rd_push_q  <= 1'b0;
            rd_data_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            last_op_q  <= last_op_d;
            cnt_q      <= cnt_d;
            rxf_sync_q <= {rxf_sync_q[0], rxf_n};
            txe_sync_q <= {txe_sync_q[0], txe_n};
            rd_n_q     <= (state_d != RD_STROBE);
            wr_n_q     <= (state_d != WR_STROBE);
            dq_oe_q    <= (state_d inside {WR_SETUP, WR_STROBE, WR_HOLD});
            // The byte is latched as rd_n rises and enters the RX buffer one edge later.
            rd_push_q  <= rd_capture;
            if (rd_capture) rd_data_q <= dq;
            if (wr_load)    wr_data_q <= tx_head;
        end
    end

    assign rd_n = rd_n_q;
    assign wr_n = wr_n_q;
    assign dq   = dq_oe_q ? wr_data_q : {FTDI_DW{1'bz}};

    sync_fifo #(.WIDTH(FTDI_DW), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk     (clk),
        .n_rst   (n_rst),
        .push_i  (rd_push_q),
        .wdata_i (rd_data_q),
        .pop_i   (rx_valid & rx_ready),
        .rdata_o (rx_data),
        .full_o  (rx_full),
        .empty_o (rx_empty),
        .level_o (rx_level)
    );

    assign rx_valid = ~rx_empty;

    // A full TX buffer still accepts a byte on the edge a write pops one out.
    assign tx_ready = ~tx_full | tx_pop;

    sync_fifo #(.WIDTH(FTDI_DW), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk     (clk),
        .n_rst   (n_rst),
        .push_i  (tx_valid & tx_ready),
        .wdata_i (tx_data),
        .pop_i   (tx_pop),
        .rdata_o (tx_head),
        .full_o  (tx_full),
        .empty_o (tx_empty),
        .level_o (tx_level)
    );

endmodule

// File: tb/tb_ftdi_fifo_bridge.sv
// Directed bench for ftdi_fifo_bridge with a behavioural FT245 pin model.
module tb_ftdi_fifo_bridge;

    typedef struct {
        logic       is_wr;
        logic [7:0] data;
        int         exp_width;
        logic [7:0] exp_byte;
        int         exp_level;
    } vec_t;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       rxf_n, txe_n;
    logic       rd_n, wr_n;
    wire  [7:0] dq;
    logic [7:0] rx_data, tx_data;
    logic       rx_valid, rx_ready, tx_valid, tx_ready;
    logic [4:0] rx_level, tx_level;

    int n_checks, n_fail;

    // FTDI model state
    logic [7:0] rx_src [128];
    int         rx_total;
    logic       probe_en;
    int         rd_cnt, wr_cnt, rd_run, wr_run, last_rd_w, last_wr_w, overlap, ord_n;
    logic [7:0] wr_byte_run;
    logic [7:0] tx_cap [128];
    logic       ord [128];

    always #5 clk = ~clk;

    ftdi_fifo_bridge dut (
        .clk      (clk),
        .n_rst    (n_rst),
        .rxf_n    (rxf_n),
        .txe_n    (txe_n),
        .rd_n     (rd_n),
        .wr_n     (wr_n),
        .dq       (dq),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .rx_level (rx_level),
        .tx_level (tx_level)
    );

    assign rxf_n = (rx_total == rd_cnt);
    assign dq    = !rd_n ? rx_src[rd_cnt[6:0]] : (probe_en ? 8'h5A : 8'hzz);

    initial begin
        rd_cnt = 0; wr_cnt = 0; rd_run = 0; wr_run = 0;
        last_rd_w = 0; last_wr_w = 0; overlap = 0; ord_n = 0; wr_byte_run = '0;
    end

    always @(negedge clk) begin
        if (!rd_n && !wr_n) overlap++;
        if (!rd_n) begin
            if (rd_run == 0) begin ord[ord_n[6:0]] = 1'b0; ord_n++; end
            rd_run++;
        end else if (rd_run != 0) begin
            last_rd_w = rd_run; rd_run = 0; rd_cnt++;
        end
        if (!wr_n) begin
            if (wr_run == 0) begin ord[ord_n[6:0]] = 1'b1; ord_n++; end
            wr_run++;
            wr_byte_run = dq;
        end else if (wr_run != 0) begin
            last_wr_w = wr_run; wr_run = 0;
            tx_cap[wr_cnt[6:0]] = wr_byte_run;
            wr_cnt++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic post_rx(input logic [7:0] b);
        rx_src[rx_total[6:0]] = b;
        rx_total++;
    endtask

    task automatic push_tx(input logic [7:0] b);
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic pop_rx();
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    // d_off: bus with the probe off; d_on: bus with the probe driving 0x5A (reads 0x5A only if the DUT is released).
    task automatic sample_dq(output logic [7:0] d_off, output logic [7:0] d_on);
        probe_en = 1'b0;
        #1 d_off = dq;
        probe_en = 1'b1;
        #1 d_on = dq;
        probe_en = 1'b0;
    endtask

    vec_t       vecs [8];
    logic       exp_wr_n [6];
    logic       exp_drv  [6];
    int         exp_lvl  [6];
    logic [7:0] d_off, d_on, exp_b;
    int         lat, w, base_rd, base_wr, base_ord, exp_idx, t, nxt, min_lvl, idx;
    logic       acc;

    initial begin
        n_checks = 0; n_fail = 0;
        rx_total = 0; probe_en = 1'b0;
        txe_n = 1'b1; rx_ready = 1'b0; tx_valid = 1'b0; tx_data = '0;
        n_rst = 1'b0;

        vecs[0] = '{1'b0, 8'h00, 2, 8'h00, 1};
        vecs[1] = '{1'b1, 8'hFF, 2, 8'hFF, 0};
        vecs[2] = '{1'b0, 8'h5A, 2, 8'h5A, 1};
        vecs[3] = '{1'b1, 8'h81, 2, 8'h81, 0};
        vecs[4] = '{1'b0, 8'hFF, 2, 8'hFF, 1};
        vecs[5] = '{1'b1, 8'h00, 2, 8'h00, 0};
        vecs[6] = '{1'b0, 8'h3C, 2, 8'h3C, 1};
        vecs[7] = '{1'b1, 8'hC3, 2, 8'hC3, 0};
        exp_wr_n = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        exp_drv  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        exp_lvl  = '{1, 1, 1, 1, 0, 0};

        // Reset state
        repeat (3) @(negedge clk);
        sample_dq(d_off, d_on);
        check("reset_rd_n", rd_n, 1);
        check("reset_wr_n", wr_n, 1);
        check("reset_dq_released", d_on, 8'h5A);
        check("reset_rx_valid", rx_valid, 0);
        check("reset_rx_data", rx_data, 0);
        check("reset_tx_ready", tx_ready, 1);
        check("reset_rx_level", rx_level, 0);
        check("reset_tx_level", tx_level, 0);
        n_rst = 1'b1;
        repeat (3) @(negedge clk);

        // Single read: latency, strobe width, rx_valid timing
        post_rx(8'hA5);
        lat = 0;
        while (rd_n && lat < 20) begin @(negedge clk); lat++; end
        check("rd_latency", lat, 3);
        w = 0;
        while (!rd_n && w < 20) begin @(negedge clk); w++; end
        check("rd_low_cycles", w, 2);
        check("rx_valid_at_rd_rise", rx_valid, 0);
        @(negedge clk);
        check("rx_valid_after_1", rx_valid, 1);
        check("rx_data_a5", rx_data, 8'hA5);
        check("rx_level_1", rx_level, 1);
        pop_rx();
        check("rx_level_after_pop", rx_level, 0);
        check("rx_valid_after_pop", rx_valid, 0);
        repeat (6) @(negedge clk);

        // Table of single transfers in each direction
        txe_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            base_rd = rd_cnt;
            base_wr = wr_cnt;
            if (!vecs[i].is_wr) begin
                post_rx(vecs[i].data);
                repeat (12) @(negedge clk);
                check($sformatf("vec%0d_rd_count", i), rd_cnt - base_rd, 1);
                check($sformatf("vec%0d_rd_width", i), last_rd_w, vecs[i].exp_width);
                check($sformatf("vec%0d_rx_data", i), rx_data, vecs[i].exp_byte);
                check($sformatf("vec%0d_rx_level", i), rx_level, vecs[i].exp_level);
                pop_rx();
            end else begin
                push_tx(vecs[i].data);
                repeat (12) @(negedge clk);
                check($sformatf("vec%0d_wr_count", i), wr_cnt - base_wr, 1);
                check($sformatf("vec%0d_wr_width", i), last_wr_w, vecs[i].exp_width);
                check($sformatf("vec%0d_wr_byte", i), tx_cap[base_wr[6:0]], vecs[i].exp_byte);
                check($sformatf("vec%0d_tx_level", i), tx_level, vecs[i].exp_level);
            end
        end

        // Single write: dq window around the wr_n pulse, cycle by cycle
        tx_data  = 8'h3C;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        for (int k = 0; k < 6; k++) begin
            sample_dq(d_off, d_on);
            check($sformatf("wr_seq%0d_wr_n", k), wr_n, exp_wr_n[k]);
            if (exp_drv[k]) check($sformatf("wr_seq%0d_dq_driven", k), d_off, 8'h3C);
            else            check($sformatf("wr_seq%0d_dq_released", k), d_on, 8'h5A);
            check($sformatf("wr_seq%0d_tx_level", k), tx_level, exp_lvl[k]);
            @(negedge clk);
        end
        repeat (6) @(negedge clk);

        // RX backpressure: 20 bytes offered, only 16 fit
        base_rd = rd_cnt;
        for (int i = 0; i < 20; i++) post_rx(8'h10 + 8'(i));
        repeat (200) @(negedge clk);
        check("bp_reads_16", rd_cnt - base_rd, 16);
        check("bp_rx_level_16", rx_level, 16);
        check("bp_rd_n_high", rd_n, 1);
        repeat (30) @(negedge clk);
        check("bp_no_extra_read", rd_cnt - base_rd, 16);
        pop_rx();
        repeat (30) @(negedge clk);
        check("bp_one_more_read", rd_cnt - base_rd, 17);
        check("bp_rx_level_refilled", rx_level, 16);
        rx_ready = 1'b1;
        exp_idx = 1;
        t = 0;
        while (exp_idx < 20 && t < 600) begin
            if (rx_valid) begin
                exp_b = 8'h10 + 8'(exp_idx);
                check($sformatf("bp_order%0d", exp_idx), rx_data, exp_b);
                exp_idx++;
            end
            @(negedge clk);
            t++;
        end
        rx_ready = 1'b0;
        check("bp_drain_complete", exp_idx, 20);
        repeat (10) @(negedge clk);

        // TX full with simultaneous push/pop
        txe_n = 1'b1;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            tx_data  = 8'hC0 + 8'(i);
            tx_valid = 1'b1;
            @(negedge clk);
        end
        tx_valid = 1'b0;
        check("txfull_level_16", tx_level, 16);
        check("txfull_tx_ready_0", tx_ready, 0);
        base_wr  = wr_cnt;
        nxt      = 0;
        min_lvl  = 16;
        t        = 0;
        tx_data  = 8'hD0;
        tx_valid = 1'b1;
        txe_n    = 1'b0;
        while (nxt < 4 && t < 200) begin
            acc = tx_ready;
            if (int'(tx_level) < min_lvl) min_lvl = int'(tx_level);
            @(negedge clk);
            t++;
            if (acc) begin
                nxt++;
                tx_data = 8'hD0 + 8'(nxt);
            end
        end
        tx_valid = 1'b0;
        check("txfull_pushes_4", nxt, 4);
        check("txfull_level_held_16", min_lvl, 16);
        repeat (250) @(negedge clk);
        check("txfull_writes_20", wr_cnt - base_wr, 20);
        for (int i = 0; i < 20; i++) begin
            idx   = base_wr + i;
            exp_b = (i < 16) ? 8'hC0 + 8'(i) : 8'hD0 + 8'(i - 16);
            check($sformatf("txfull_order%0d", i), tx_cap[idx[6:0]], exp_b);
        end
        check("txfull_drained", tx_level, 0);

        // Reset in the middle of a write strobe
        push_tx(8'hE7);
        w = 0;
        while (wr_n && w < 20) begin @(negedge clk); w++; end
        check("rst_in_wr_strobe", wr_n, 0);
        #1 n_rst = 1'b0;
        #1;
        check("rst_async_wr_n", wr_n, 1);
        check("rst_async_rd_n", rd_n, 1);
        sample_dq(d_off, d_on);
        check("rst_async_dq_released", d_on, 8'h5A);
        @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
        check("rst_tx_level", tx_level, 0);
        check("rst_tx_ready", tx_ready, 1);
        check("rst_rx_level", rx_level, 0);
        check("rst_wr_n_after", wr_n, 1);

        // Arbitration: both directions pending after reset
        txe_n = 1'b1;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 4; i++) push_tx(8'hB0 + 8'(i));
        base_rd  = rd_cnt;
        base_wr  = wr_cnt;
        base_ord = ord_n;
        for (int i = 0; i < 4; i++) post_rx(8'h70 + 8'(i));
        txe_n = 1'b0;
        repeat (120) @(negedge clk);
        check("arb_strobes_8", ord_n - base_ord, 8);
        for (int k = 0; k < 8; k++) begin
            idx = base_ord + k;
            check($sformatf("arb_order%0d", k), ord[idx[6:0]], k % 2);
        end
        for (int i = 0; i < 4; i++) begin
            idx   = base_wr + i;
            exp_b = 8'hB0 + 8'(i);
            check($sformatf("arb_tx_byte%0d", i), tx_cap[idx[6:0]], exp_b);
        end
        check("arb_rx_level_4", rx_level, 4);
        for (int i = 0; i < 4; i++) begin
            exp_b = 8'h70 + 8'(i);
            check($sformatf("arb_rx_byte%0d", i), rx_data, exp_b);
            pop_rx();
        end
        check("no_strobe_overlap", overlap, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
